async_fifo_lvl: RTL

//   Dual-clock FIFO with Gray-code pointer crossing and a configurable synchroniser depth.

---
 rtl/async_fifo_lvl.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/async_fifo_lvl.sv
// async_fifo_lvl: dual-clock FIFO with Gray pointer crossing, fill levels, threshold flags and sticky errors.
// Define ASYNC_FIFO_FWFT_EN for first-word-fall-through reads; default is a registered 1-cycle read.
module async_fifo_lvl #(
   parameter int DATA_WIDTH    = 8,
   parameter int ADDR_WIDTH    = 4,
   parameter int SYNC_STAGES   = 2,
   parameter int AFULL_THRESH  = (1 << ADDR_WIDTH) - 2,
   parameter int AEMPTY_THRESH = 2
) (
   input  logic                  wr_clk,
   input  logic                  rst,
   input  logic                  rd_clk,
   input  logic                  wr_en,
   input  logic [DATA_WIDTH-1:0] din,
   output logic                  full,
   output logic                  almost_full,
   output logic [ADDR_WIDTH:0]   wr_count,
   output logic                  wr_overflow,
   input  logic                  rd_en,
   output logic [DATA_WIDTH-1:0] dout,
   output logic                  empty,
   output logic                  almost_empty,
   output logic [ADDR_WIDTH:0]   rd_count,
   output logic                  rd_underflow
);
   localparam int DEPTH = 1 << ADDR_WIDTH;
   localparam int PW    = ADDR_WIDTH + 1;
   localparam logic [PW-1:0] PTR_ONE   = PW'(1);
   // Gray code of (ptr + DEPTH) is the Gray code of ptr with its two top bits inverted.
   localparam logic [PW-1:0] FULL_MASK = PW'(3) << (ADDR_WIDTH - 1);
   localparam logic [PW-1:0] AFULL_C   = PW'(AFULL_THRESH);
   localparam logic [PW-1:0] AEMPTY_C  = PW'(AEMPTY_THRESH);

   generate
      if (AFULL_THRESH > DEPTH || AEMPTY_THRESH > DEPTH) begin : g_thresh_err
         $error("async_fifo_lvl: AFULL_THRESH/AEMPTY_THRESH must not exceed DEPTH");
      end
      if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_sync_err
         $error("async_fifo_lvl: SYNC_STAGES must be in 2..4");
      end
      if (ADDR_WIDTH < 1) begin : g_addr_err
         $error("async_fifo_lvl: ADDR_WIDTH must be >= 1");
      end
   endgenerate

   function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
      return b ^ (b >> 1);
   endfunction

   function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
      logic [PW-1:0] b;
      b[PW-1] = g[PW-1];
      for (int i = PW - 2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];

   logic [PW-1:0] wr_bin_q, wr_bin_d, wr_gray_q;
   logic [PW-1:0] rd_gray_sync_q [SYNC_STAGES];
   logic [PW-1:0] rd_gray_s;
   logic          wr_ovf_q;
   logic          wr_push;

   logic [PW-1:0] rd_bin_q, rd_bin_d, rd_gray_q;
   logic [PW-1:0] wr_gray_sync_q [SYNC_STAGES];
   logic [PW-1:0] wr_gray_s, wr_bin_s;
   logic [DATA_WIDTH-1:0] dout_q, dout_d;
   logic          rd_unf_q;
   logic          mem_empty;
   logic          rd_pop;

   // ---------------- write domain ----------------
   assign rd_gray_s   = rd_gray_sync_q[SYNC_STAGES-1];
   assign full        = (wr_gray_q == (rd_gray_s ^ FULL_MASK));
   assign wr_push     = wr_en && !full;
   assign wr_bin_d    = wr_push ? (wr_bin_q + PTR_ONE) : wr_bin_q;
   assign wr_count    = wr_bin_q - gray2bin(rd_gray_s);
   assign almost_full = (wr_count >= AFULL_C);
   assign wr_overflow = wr_ovf_q;

   always_ff @(posedge wr_clk or posedge rst) begin
      if (rst) begin
         wr_bin_q  <= '0;
         wr_gray_q <= '0;
         wr_ovf_q  <= 1'b0;
         for (int i = 0; i < SYNC_STAGES; i++) begin
            rd_gray_sync_q[i] <= '0;
         end
      end else begin
         wr_bin_q  <= wr_bin_d;
         wr_gray_q <= bin2gray(wr_bin_d);
         if (wr_en && full) begin
            wr_ovf_q <= 1'b1;
         end
         rd_gray_sync_q[0] <= rd_gray_q;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            rd_gray_sync_q[i] <= rd_gray_sync_q[i-1];
         end
      end
   end

   always_ff @(posedge wr_clk) begin
      if (wr_push) begin
         mem_q[wr_bin_q[ADDR_WIDTH-1:0]] <= din;
      end
   end

   // ---------------- read domain ----------------
   assign wr_gray_s    = wr_gray_sync_q[SYNC_STAGES-1];
   assign wr_bin_s     = gray2bin(wr_gray_s);
   assign mem_empty    = (rd_gray_q == wr_gray_s);
   assign rd_bin_d     = rd_pop ? (rd_bin_q + PTR_ONE) : rd_bin_q;
   assign dout_d       = rd_pop ? mem_q[rd_bin_q[ADDR_WIDTH-1:0]] : dout_q;
   assign dout         = dout_q;
   assign almost_empty = (rd_count <= AEMPTY_C);
   assign rd_underflow = rd_unf_q;

`ifdef ASYNC_FIFO_FWFT_EN
   logic out_vld_q, out_vld_d;

   // The output register refills whenever it is vacant or being consumed this cycle.
   assign rd_pop    = !mem_empty && (!out_vld_q || rd_en);
   assign out_vld_d = rd_pop ? 1'b1 : (rd_en ? 1'b0 : out_vld_q);
   assign empty     = !out_vld_q;
   assign rd_count  = wr_bin_s - rd_bin_q + PW'(out_vld_q);

   always_ff @(posedge rd_clk or posedge rst) begin
      if (rst) begin
         out_vld_q <= 1'b0;
      end else begin
         out_vld_q <= out_vld_d;
      end
   end
`else
   assign rd_pop   = rd_en && !mem_empty;
   assign empty    = mem_empty;
   assign rd_count = wr_bin_s - rd_bin_q;
`endif

   always_ff @(posedge rd_clk or posedge rst) begin
      if (rst) begin
         rd_bin_q  <= '0;
         rd_gray_q <= '0;
         dout_q    <= '0;
         rd_unf_q  <= 1'b0;
         for (int i = 0; i < SYNC_STAGES; i++) begin
            wr_gray_sync_q[i] <= '0;
         end
      end else begin
         rd_bin_q  <= rd_bin_d;
         rd_gray_q <= bin2gray(rd_bin_d);
         dout_q    <= dout_d;
         if (rd_en && empty) begin
            rd_unf_q <= 1'b1;
         end
         wr_gray_sync_q[0] <= wr_gray_q;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            wr_gray_sync_q[i] <= wr_gray_sync_q[i-1];
         end
      end
   end

endmodule
